tlc_param_ctrl: RTL and testbench



---
 rtl/tlc_param_ctrl_pkg.sv | 45 ++++
 rtl/tlc_param_ctrl_if.sv | 32 +++
 rtl/tlc_param_ctrl_phase_timer.sv | 21 ++
 rtl/tlc_param_ctrl.sv | 92 +++++++++
 tb/tb_tlc_param_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/tlc_param_ctrl_pkg.sv
// Shared types for the parametrised highway/farm-road traffic-light controller:
// phase codes, lamp bundle type and the phase-to-lamp decode.
// The optional all-red clearance phase is enabled with the TLC_ALL_RED_EN macro.
package tlc_pkg;

  // Phase codes are fixed so that state_o keeps the same meaning in every build.
  typedef enum logic [2:0] {
    HG   = 3'd0,
    HY   = 3'd1,
    FG   = 3'd2,
    FY   = 3'd3,
    AR_H = 3'd4,
    AR_F = 3'd5
  } phaseT;

  // Lamp bundle, bit order {hr, hy, hg, fr, fy, fg}.
  typedef struct packed {
    logic hr;
    logic hy;
    logic hg;
    logic fr;
    logic fy;
    logic fg;
  } lampsT;

  localparam lampsT LAMPS_HG      = 6'b001_100;
  localparam lampsT LAMPS_HY      = 6'b010_100;
  localparam lampsT LAMPS_FG      = 6'b100_001;
  localparam lampsT LAMPS_FY      = 6'b100_010;
  localparam lampsT LAMPS_ALL_RED = 6'b100_100;

  // Unknown codes decode to all-red so a corrupted state never shows two greens.
  function automatic lampsT lampsFor(phaseT phase);
    lampsT lamps;
    case (phase)
      HG:      lamps = LAMPS_HG;
      HY:      lamps = LAMPS_HY;
      FG:      lamps = LAMPS_FG;
      FY:      lamps = LAMPS_FY;
      default: lamps = LAMPS_ALL_RED;
    endcase
    return lamps;
  endfunction

endpackage

// File: rtl/tlc_param_ctrl_if.sv
// Bundle of the controller's settings, sensor input and lamp/status outputs.
// The master side supplies settings and the sensor; the slave side is the controller.
// The TLC_ALL_RED_EN macro decides whether clr_time_i has any effect.
interface tlc_param_ctrl_if #(
  parameter int CNT_W = 6
);

  logic             car_i;
  logic [CNT_W-1:0] short_time_i;
  logic [CNT_W-1:0] long_time_i;
  logic [CNT_W-1:0] clr_time_i;

  logic             hr;
  logic             hy;
  logic             hg;
  logic             fr;
  logic             fy;
  logic             fg;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] timer_o;

  modport master (
    output car_i, short_time_i, long_time_i, clr_time_i,
    input  hr, hy, hg, fr, fy, fg, state_o, timer_o
  );

  modport slave (
    input  car_i, short_time_i, long_time_i, clr_time_i,
    output hr, hy, hg, fr, fy, fg, state_o, timer_o
  );

endinterface

// File: rtl/tlc_param_ctrl_phase_timer.sv
// Shared phase timer: synchronous clear, otherwise counts up one per cycle
// and parks at all-ones instead of wrapping, so a long-held phase never
// looks freshly entered. Unaffected by the TLC_ALL_RED_EN macro.
module tlc_phase_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             clear,
  output logic [CNT_W-1:0] t
);

  // Clear has priority; the increment stops once the counter is saturated.
  always_ff @(posedge clk) begin
    if (clear) begin
      t <= '0;
    end else if (t != '1) begin
      t <= t + 1'b1;
    end
  end

endmodule

// File: rtl/tlc_param_ctrl.sv
// Top-level highway/farm-road traffic-light controller with a single shared
// phase timer, farm-road gap-out and live (unlatched) time settings.
// Define TLC_ALL_RED_EN to insert the all-red clearance phases AR_H / AR_F.
module tlc_param_ctrl
  import tlc_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  tlc_param_ctrl_if.slave        bus
);

  phaseT            state;
  phaseT            nextState;
  logic [CNT_W-1:0] t;
  logic             timerClear;
  lampsT            lamps;

  // Reset and every phase change restart the timer so each phase counts from 0.
  assign timerClear = rst || (nextState != state);

  tlc_phase_timer #(
    .CNT_W (CNT_W)
  ) phaseTimer (
    .clk   (clk),
    .clear (timerClear),
    .t     (t)
  );

  // State register; reset wins over any pending transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HG;
    end else begin
      state <= nextState;
    end
  end

  // Next-phase rules; all limits are >= so a setting lowered mid-phase ends it promptly.
  // The AR rows exist in every build but are only reachable with the macro defined.
  always_comb begin
    nextState = state;
    case (state)
      HG: begin
        if (bus.car_i && (t >= bus.long_time_i)) nextState = HY;
      end
      HY: begin
        if (t >= bus.short_time_i) begin
`ifdef TLC_ALL_RED_EN
          nextState = AR_H;
`else
          nextState = FG;
`endif
        end
      end
      AR_H: begin
        if (t >= bus.clr_time_i) nextState = FG;
      end
      FG: begin
        if (!bus.car_i || (t >= bus.long_time_i)) nextState = FY;
      end
      FY: begin
        if (t >= bus.short_time_i) begin
`ifdef TLC_ALL_RED_EN
          nextState = AR_F;
`else
          nextState = HG;
`endif
        end
      end
      AR_F: begin
        if (t >= bus.clr_time_i) nextState = HG;
      end
      default: nextState = HG;
    endcase
  end

  // Moore outputs decoded purely from the state and timer registers.
  always_comb begin
    lamps       = lampsFor(state);
    bus.hr      = lamps.hr;
    bus.hy      = lamps.hy;
    bus.hg      = lamps.hg;
    bus.fr      = lamps.fr;
    bus.fy      = lamps.fy;
    bus.fg      = lamps.fg;
    bus.state_o = state;
    bus.timer_o = t;
  end

endmodule

// File: tb/tb_tlc_param_ctrl.sv
// Self-checking bench for tlc_param_ctrl: one 6-bit and one 8-bit instance,
// a cycle-level phase model, and directed runs with literal phase lengths.
// Honours TLC_ALL_RED_EN the same way the design does.
module tb_tlc_param_ctrl;

`ifdef TLC_ALL_RED_EN
  localparam bit ALL_RED = 1'b1;
`else
  localparam bit ALL_RED = 1'b0;
`endif

  logic clk = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic       rstV   [2];
  logic       car    [2];
  logic [7:0] shortT [2];
  logic [7:0] longT  [2];
  logic [7:0] clrT   [2];

  tlc_param_ctrl_if #(.CNT_W(6)) bus6 ();
  tlc_param_ctrl_if #(.CNT_W(8)) bus8 ();

  assign bus6.car_i        = car[0];
  assign bus6.short_time_i = shortT[0][5:0];
  assign bus6.long_time_i  = longT[0][5:0];
  assign bus6.clr_time_i   = clrT[0][5:0];
  assign bus8.car_i        = car[1];
  assign bus8.short_time_i = shortT[1];
  assign bus8.long_time_i  = longT[1];
  assign bus8.clr_time_i   = clrT[1];

  tlc_param_ctrl #(.CNT_W(6)) dut6 (.clk(clk), .rst(rstV[0]), .bus(bus6));
  tlc_param_ctrl #(.CNT_W(8)) dut8 (.clk(clk), .rst(rstV[1]), .bus(bus8));

  always #5 clk = ~clk;

  // Lamp patterns per phase code, {hr,hy,hg,fr,fy,fg}, written out by hand.
  logic [5:0] lampLit [6] = '{6'b001100, 6'b010100, 6'b100001,
                              6'b100010, 6'b100100, 6'b100100};

  function automatic void getObs(input int d, output int st, output int tm,
                                 output logic [5:0] lp);
    if (d == 0) begin
      st = int'(bus6.state_o);
      tm = int'(bus6.timer_o);
      lp = {bus6.hr, bus6.hy, bus6.hg, bus6.fr, bus6.fy, bus6.fg};
    end else begin
      st = int'(bus8.state_o);
      tm = int'(bus8.timer_o);
      lp = {bus8.hr, bus8.hy, bus8.hg, bus8.fr, bus8.fy, bus8.fg};
    end
  endfunction

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  mPh    [2];
  int  mT     [2];
  bit  mValid [2] = '{1'b0, 1'b0};
  int  maxT   [2] = '{63, 255};
  int  widthMask [2] = '{63, 255};

  // Model advances on each rising edge from the settings applied at that edge.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int  sh, lg, cl, succ;
      bit  leave;
      sh = int'(shortT[d]) & widthMask[d];
      lg = int'(longT[d]) & widthMask[d];
      cl = int'(clrT[d]) & widthMask[d];
      if (rstV[d]) begin
        mPh[d] = 0; mT[d] = 0; mValid[d] = 1'b1;
      end else if (mValid[d]) begin
        leave = 1'b0; succ = 0;
        case (mPh[d])
          0: begin leave = car[d] && (mT[d] >= lg); succ = 1; end
          1: begin leave = mT[d] >= sh; succ = ALL_RED ? 4 : 2; end
          4: begin leave = mT[d] >= cl; succ = 2; end
          2: begin leave = !car[d] || (mT[d] >= lg); succ = 3; end
          3: begin leave = mT[d] >= sh; succ = ALL_RED ? 5 : 0; end
          default: begin leave = mT[d] >= cl; succ = 0; end
        endcase
        if (leave) begin
          mPh[d] = succ; mT[d] = 0;
        end else if (mT[d] < maxT[d]) begin
          mT[d] = mT[d] + 1;
        end
      end
    end
  end

  // Compare every meaningful cycle, away from the rising edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int st, tm;
      logic [5:0] lp, mLp;
      if (mValid[d]) begin
        getObs(d, st, tm, lp);
        mLp = {mPh[d] >= 2, mPh[d] == 1, mPh[d] == 0,
               (mPh[d] <= 1) || (mPh[d] >= 4), mPh[d] == 3, mPh[d] == 2};
        checkOutput($sformatf("model state dut%0d", d), st, mPh[d]);
        checkOutput($sformatf("model timer dut%0d", d), tm, mT[d]);
        checkOutput($sformatf("model lamps dut%0d", d), int'(lp), int'(mLp));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic applyStimulus(input int d, input logic c, input int sh,
                               input int lg, input int cl);
    car[d]    = c;
    shortT[d] = sh[7:0];
    longT[d]  = lg[7:0];
    clrT[d]   = cl[7:0];
  endtask

  // Called at a falling edge; leaves the reset state visible on return.
  task automatic doReset(input int d);
    rstV[d] = 1'b1;
    repeat (2) @(negedge clk);
    rstV[d] = 1'b0;
  endtask

  // Expect phase ph for n cycles with timer counting from t0, literal lamps.
  task automatic expectRun(input int d, input int ph, input int n, input int t0,
                           input string tag);
    int st, tm;
    logic [5:0] lp;
    for (int k = 0; k < n; k++) begin
      getObs(d, st, tm, lp);
      checkOutput($sformatf("%s state k=%0d", tag, k), st, ph);
      checkOutput($sformatf("%s timer k=%0d", tag, k), tm, t0 + k);
      checkOutput($sformatf("%s lamps k=%0d", tag, k), int'(lp), int'(lampLit[ph]));
      @(negedge clk);
    end
  endtask

  initial begin
    int st, tm;
    logic [5:0] lp;
    rstV[0] = 1'b1; rstV[1] = 1'b1;
    applyStimulus(0, 1'b0, 3, 10, 2);
    applyStimulus(1, 1'b0, 2, 5, 2);
    repeat (2) @(negedge clk);
    rstV[0] = 1'b0; rstV[1] = 1'b0;

    // Reset state and HG hold with no farm traffic.
    getObs(0, st, tm, lp);
    checkOutput("reset state", st, 0);
    checkOutput("reset timer", tm, 0);
    checkOutput("reset lamps", int'(lp), int'(6'b001100));
    repeat (100) @(negedge clk);
    getObs(0, st, tm, lp);
    checkOutput("hold state", st, 0);
    checkOutput("hold timer saturated", tm, 63);

    // Full cycle with max-out in FG.
    if (ALL_RED) applyStimulus(0, 1'b1, 1, 4, 2);
    else         applyStimulus(0, 1'b1, 3, 10, 2);
    doReset(0);
    if (ALL_RED) begin
      expectRun(0, 0, 5, 0, "ar HG");
      expectRun(0, 1, 2, 0, "ar HY");
      expectRun(0, 4, 3, 0, "ar AR_H");
      expectRun(0, 2, 5, 0, "ar FG");
      expectRun(0, 3, 2, 0, "ar FY");
      expectRun(0, 5, 3, 0, "ar AR_F");
      expectRun(0, 0, 1, 0, "ar HG again");
    end else begin
      expectRun(0, 0, 11, 0, "full HG");
      expectRun(0, 1, 4, 0, "full HY");
      expectRun(0, 2, 11, 0, "full FG");
      expectRun(0, 3, 4, 0, "full FY");
      expectRun(0, 0, 1, 0, "full HG again");
    end

    // Gap-out: car leaves at FG t=5.
    applyStimulus(0, 1'b1, 2, 20, 2);
    doReset(0);
    expectRun(0, 0, 21, 0, "gap HG");
    expectRun(0, 1, 3, 0, "gap HY");
    if (ALL_RED) expectRun(0, 4, 3, 0, "gap AR_H");
    expectRun(0, 2, 5, 0, "gap FG");
    car[0] = 1'b0;
    expectRun(0, 2, 1, 5, "gap FG last");
    expectRun(0, 3, 3, 0, "gap FY");
    if (ALL_RED) expectRun(0, 5, 3, 0, "gap AR_F");
    expectRun(0, 0, 3, 0, "gap HG held");

    // Zero settings: every phase lasts one cycle.
    applyStimulus(0, 1'b1, 0, 0, 0);
    doReset(0);
    expectRun(0, 0, 1, 0, "zero HG");
    expectRun(0, 1, 1, 0, "zero HY");
    if (ALL_RED) expectRun(0, 4, 1, 0, "zero AR_H");
    expectRun(0, 2, 1, 0, "zero FG");
    expectRun(0, 3, 1, 0, "zero FY");
    if (ALL_RED) expectRun(0, 5, 1, 0, "zero AR_F");
    expectRun(0, 0, 1, 0, "zero HG again");

    // 8-bit instance: reset asserted at FG t=3.
    applyStimulus(1, 1'b1, 2, 5, 2);
    doReset(1);
    expectRun(1, 0, 6, 0, "rst8 HG");
    expectRun(1, 1, 3, 0, "rst8 HY");
    if (ALL_RED) expectRun(1, 4, 3, 0, "rst8 AR_H");
    expectRun(1, 2, 3, 0, "rst8 FG");
    rstV[1] = 1'b1;
    expectRun(1, 2, 1, 3, "rst8 FG t3");
    expectRun(1, 0, 1, 0, "rst8 back to HG");
    rstV[1] = 1'b0;

    // 8-bit instance: long setting lowered below t during HG.
    applyStimulus(1, 1'b1, 2, 30, 2);
    doReset(1);
    expectRun(1, 0, 10, 0, "lower HG");
    longT[1] = 8'd2;
    expectRun(1, 0, 1, 10, "lower HG t10");
    expectRun(1, 1, 1, 0, "lower HY");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
